// File: rtl/ub_burst_arbiter.sv
// Round-robin burst arbiter for the single-port unified buffer; one whole burst per grant, one beat per cycle.
// Define UB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (highest index wins).
module ub_burst_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          beat,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NREQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]        rd_data
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state;
    logic [ID_W-1:0]     id;
    logic [ID_W-1:0]     win;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    len_q;
    logic                we_q;
    logic [ADDR_W-1:0]   base_q;
    logic                rd_pend;
    logic [ID_W-1:0]     rd_id;
    logic [NREQ-1:0]     own;

`ifdef UB_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req[k]) win = ID_W'(k);
        end
    end
`else
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     rr_idx;

    // Scan from the far end back toward ptr so the last hit is the first requester at or after ptr.
    always_comb begin
        win    = '0;
        rr_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            rr_idx = ID_W'((int'(ptr) + k) % NREQ);
            if (req[rr_idx]) win = rr_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (state == IDLE && |req) begin
            ptr <= ID_W'((int'(win) + 1) % NREQ);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            id      <= '0;
            cnt     <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            base_q  <= '0;
            rd_pend <= 1'b0;
            rd_id   <= '0;
        end else begin
            // Read data arrives from the macro one cycle after the access; tag it with the owner.
            rd_pend <= (state == BURST) && !we_q;
            rd_id   <= id;
            case (state)
                IDLE: begin
                    if (|req) begin
                        id     <= win;
                        base_q <= req_addr[win*ADDR_W +: ADDR_W];
                        len_q  <= req_len[win*LEN_W +: LEN_W];
                        we_q   <= req_we[win];
                        cnt    <= '0;
                        state  <= BURST;
                    end
                end
                BURST: begin
                    if (cnt == len_q) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == BURST);
    assign own       = busy ? (NREQ'(1) << id) : '0;
    assign gnt       = own;
    assign beat      = own;
    assign done      = (cnt == len_q) ? own : '0;
    assign mem_en    = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = busy ? (base_q + ADDR_W'(cnt)) : '0;
    assign mem_wdata = busy ? req_wdata[id*DATA_W +: DATA_W] : '0;
    assign rd_valid  = rd_pend ? (NREQ'(1) << rd_id) : '0;
    assign rd_data   = rd_pend ? mem_rdata : '0;

endmodule

// File: doc/ub_burst_arbiter.md
Name: ub_burst_arbiter

Overview:
- Shares the single-port unified buffer (UB) between NREQ requesters: host loader, weight loader, input loader and result store.
- Each requester asks for a burst: base address, length and direction. The arbiter grants one whole burst at a time, round-robin.
- During a burst it drives one UB access per cycle and routes read data back to the owner.
- Sits between the control unit's load/store sequencing and the UB memory macro.

Parameters:
- NREQ, 4, number of requesters (index 0 = host, 1 = weight, 2 = input, 3 = store).
- ADDR_W, 13, UB address width; matches the 13-bit instruction address field.
- DATA_W, 16, UB word width.
- LEN_W, 4, burst length field; beats = len+1 (1..16).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req  in  NREQ  per-requester burst request, level.
- req_addr  in  NREQ*ADDR_W  packed base addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_len  in  NREQ*LEN_W  packed burst lengths minus one.
- req_we  in  NREQ  1 = write burst, 0 = read burst.
- req_wdata  in  NREQ*DATA_W  packed write data; current beat's word.
- gnt  out  NREQ  one-hot owner; high for every beat of the burst.
- beat  out  NREQ  one-hot; owner's beat is accepted this cycle, so the requester advances its wdata.
- done  out  NREQ  one-hot pulse on the last beat.
- busy  out  1  high in BURST state.
- mem_en  out  1  UB access enable.
- mem_we  out  1  UB write enable.
- mem_addr  out  ADDR_W  UB address.
- mem_wdata  out  DATA_W  UB write data.
- mem_rdata  in  DATA_W  UB read data; valid 1 cycle after a read access.
- rd_valid  out  NREQ  one-hot; rd_data belongs to requester i.
- rd_data  out  DATA_W  returned read word.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; all outputs 0.
  - Round-robin pointer = 0, so requester 0 is checked first.
  - Beat counter = 0; read-return pipeline flushed, so no rd_valid from a burst in flight.
  - Reset mid-burst aborts the burst immediately, with no done pulse.
- IDLE state:
  - If any req is high, select a winner by round-robin: search from index ptr upward, wrapping.
  - Latch the winner id, req_addr, req_len and req_we.
  - ptr <= winner+1 (mod NREQ). Go to BURST.
  - No mem access in IDLE.
- BURST state, one beat per cycle:
  - mem_en=1, mem_we=latched we, mem_addr=(base+cnt) mod 2^ADDR_W. Address wrap-around is silent.
  - mem_wdata = owner's req_wdata, combinationally muxed.
  - gnt[id]=1, beat[id]=1. cnt increments each cycle.
  - When cnt==len: done[id]=1, cnt<=0, state<=IDLE.
- Latency:
  - First beat comes one cycle after req is sampled in IDLE.
  - A burst occupies len+1 cycles, plus one IDLE cycle between bursts. Throughput is (len+1)/(len+2).
- Read return: for each read beat, the next cycle gives rd_valid[id]=1 and rd_data=mem_rdata. This may overlap the following IDLE cycle.
- Requester rules:
  - Hold req, addr, len and we stable from assertion until done.
  - Deassert req at the clock edge where done is sampled high.
  - Changes to req or addr during a burst are ignored; the latched values are used.
  - req still high in the IDLE cycle after done counts as a new request.
  - Dropping req early does not cancel a granted burst.
- Simultaneous requests: exactly one grant. The others wait; none starve, since each waits at most NREQ-1 bursts.
- len=0: single-beat burst; done coincides with the only beat.
- No requests: stay in IDLE; outputs 0 apart from any pending rd_valid.

Optional Feature:
- Macro UB_ARB_FIXED_PRIO_EN.
- When defined:
  - Arbitration in IDLE is fixed priority, highest index wins, so the store requester (3) pre-empts loaders between bursts.
  - ptr is unused and does not update.
  - Starvation of low indices is allowed.
- When undefined: round-robin as above.
- Burst mechanics are identical either way.

Test Plan:
- Single write: req[1], addr=0x0100, len=3, we=1 -> gnt[1] for 4 cycles starting 1 cycle after req; mem_addr 0x100..0x103; mem_we=1; done[1] on 4th beat; then IDLE.
- Single read: req[2], addr=0x0040, len=1, we=0 -> mem_en at 0x40 and 0x41; rd_valid[2] one cycle after each beat; rd_data equals the memory model contents.
- Contention: req[0..3] all high at once, each len=0, re-requesting after done -> grants in order 0,1,2,3,0; each burst separated by one IDLE cycle. With UB_ARB_FIXED_PRIO_EN: 3,3,3…
- Wrap: addr=0x1FFE, len=3 -> mem_addr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Reset mid-burst: reset=0 during the 2nd beat of a len=7 read -> next cycle all outputs 0, no done, no stale rd_valid. After release, req[3] alone is granted 1 cycle later.
- Ignore-late-change: change req_addr to 0x0500 during a burst at 0x0200 -> addresses continue 0x0200+cnt.
